// File: rtl/frame_sequencer.sv
// Frame sequencer: on each frame tick, sweeps the frame-buffer address through
// CLEAR, COMPOSE and DISPLAY, then drains the read pipeline into the VGA plot port.
module frame_sequencer #(
    parameter int unsigned H_RES     = 160,
    parameter int unsigned V_RES     = 120,
    parameter int unsigned XW        = 8,
    parameter int unsigned YW        = 7,
    parameter int unsigned CW        = 3,
    parameter int unsigned BG_COLOUR = 0,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          iClock,
    input  logic          iResetn,
    input  logic          iFrameTick,
    input  logic          iSkipClear,
    input  logic [CW-1:0] iPixColour,
    input  logic [CW-1:0] iRdColour,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic [CW-1:0] oWrData,
    output logic          oWren,
    output logic [XW-1:0] oVgaX,
    output logic [YW-1:0] oVgaY,
    output logic [CW-1:0] oVgaColour,
    output logic          oPlot,
    output logic          oBusy,
    output logic          oFrameDone,
    output logic [7:0]    oDropCount
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_COMPOSE = 3'd2;
    localparam logic [2:0] S_DISPLAY = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [XW-1:0] X_LAST     = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_RES - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [CW-1:0] BG         = CW'(BG_COLOUR);

    logic [2:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_drain;
    logic          r_pending;
    logic          r_done;
    logic [7:0]    r_drop;

    logic          r_pv [RD_LAT];
    logic [XW-1:0] r_px [RD_LAT];
    logic [YW-1:0] r_py [RD_LAT];

    logic w_go;
    logic w_scan;
    logic w_eol;
    logic w_last;

    assign w_go   = iFrameTick | r_pending;
    assign w_scan = (r_state == S_CLEAR) || (r_state == S_COMPOSE) || (r_state == S_DISPLAY);
    assign w_eol  = (r_x == X_LAST);
    assign w_last = w_eol && (r_y == Y_LAST);

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_drain   <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_done <= 1'b0;
            // The counter wraps to (0,0) on the last pixel, so the next phase starts there with no gap.
            if (w_scan) begin
                if (w_eol) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state   <= iSkipClear ? S_COMPOSE : S_CLEAR;
                        r_pending <= 1'b0;
                    end
                end
                S_CLEAR:   if (w_last) r_state <= S_COMPOSE;
                S_COMPOSE: if (w_last) r_state <= S_DISPLAY;
                S_DISPLAY: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // One tick may queue behind a running frame; any further ones are counted as dropped.
            if ((r_state != S_IDLE) && iFrameTick) begin
                if (!r_pending)
                    r_pending <= 1'b1;
                else if (r_drop != 8'hFF)
                    r_drop <= r_drop + 1'b1;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            r_pv[0] <= (r_state == S_DISPLAY);
            r_px[0] <= r_x;
            r_py[0] <= r_y;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
            end
        end
    end

    assign oX         = r_x;
    assign oY         = r_y;
    assign oWren      = (r_state == S_CLEAR) || (r_state == S_COMPOSE);
    assign oWrData    = (r_state == S_CLEAR)   ? BG :
                        (r_state == S_COMPOSE) ? iPixColour : '0;
    assign oPlot      = r_pv[RD_LAT-1];
    assign oVgaX      = r_px[RD_LAT-1];
    assign oVgaY      = r_py[RD_LAT-1];
    assign oVgaColour = oPlot ? iRdColour : '0;
    assign oBusy      = (r_state != S_IDLE);
    assign oFrameDone = r_done;
    assign oDropCount = r_drop;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer on a 4x3 raster: expected traces are derived from cycle
// offsets within a frame, with RAM models for RD_LAT=1 and RD_LAT=2 instances.
module tb_frame_sequencer;

    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;
    localparam int M_NONE = 0, M_TWO = 1, M_RAND = 2, M_ALL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, tick, skip, tick2, skip2;
    logic [2:0] pix, rdc, pix2, rdc2;
    logic [7:0] ox, vx, ox2, vx2, drop, drop2;
    logic [6:0] oy, vy, oy2, vy2;
    logic [2:0] wrd, vc, wrd2, vc2;
    logic       wren, plot, busy, done, wren2, plot2, busy2, done2;

    frame_sequencer #(.H_RES(H), .V_RES(V), .XW(8), .YW(7), .CW(3), .BG_COLOUR(0), .RD_LAT(1)) u_dut (
        .iClock(clk), .iResetn(rstn), .iFrameTick(tick), .iSkipClear(skip),
        .iPixColour(pix), .iRdColour(rdc), .oX(ox), .oY(oy), .oWrData(wrd), .oWren(wren),
        .oVgaX(vx), .oVgaY(vy), .oVgaColour(vc), .oPlot(plot), .oBusy(busy),
        .oFrameDone(done), .oDropCount(drop));

    frame_sequencer #(.H_RES(H), .V_RES(V), .XW(8), .YW(7), .CW(3), .BG_COLOUR(0), .RD_LAT(2)) u_dut2 (
        .iClock(clk), .iResetn(rstn), .iFrameTick(tick2), .iSkipClear(skip2),
        .iPixColour(pix2), .iRdColour(rdc2), .oX(ox2), .oY(oy2), .oWrData(wrd2), .oWren(wren2),
        .oVgaX(vx2), .oVgaY(vy2), .oVgaColour(vc2), .oPlot(plot2), .oBusy(busy2),
        .oFrameDone(done2), .oDropCount(drop2));

    logic [2:0] tbl  [N];
    logic [2:0] tbl2 [N];
    logic [2:0] ram1 [N];
    logic [2:0] ram2 [N];
    logic [2:0] rdq1, rdq2a, rdq2b;
    int a1, a2;
    bit ok1, ok2;

    always_comb begin
        a1   = int'(oy) * H + int'(ox);
        a2   = int'(oy2) * H + int'(ox2);
        ok1  = (ox < 8'(H)) && (oy < 7'(V));
        ok2  = (ox2 < 8'(H)) && (oy2 < 7'(V));
        pix  = ok1 ? tbl[a1] : 3'd0;
        pix2 = ok2 ? tbl2[a2] : 3'd0;
        rdc  = rdq1;
        rdc2 = rdq2b;
    end

    always @(posedge clk) begin
        if (wren && ok1) ram1[a1] <= wrd;
        if (wren2 && ok2) ram2[a2] <= wrd2;
        rdq1  <= ok1 ? ram1[a1] : 3'd0;
        rdq2a <= ok2 ? ram2[a2] : 3'd0;
        rdq2b <= rdq2a;
    end

    int checks = 0;
    int failures = 0;
    int drop_m = 0;
    bit pend_m = 0;

    // Caller holds the start condition (tick or pending) in the cycle before the first negedge here.
    task automatic run_frame(input bit sk, input int mode);
        int P, total, ds, ph, pi, ta, tb;
        logic [7:0] e_x, e_vx;
        logic [6:0] e_y, e_vy;
        logic [2:0] e_wd, e_vc;
        logic e_wren, e_plot, e_busy, e_done;
        bit t;
        P = sk ? 2 : 3;
        total = P * N + 1;
        ds = (P - 1) * N + 1;
        ta = $urandom_range(1, 10);
        tb = ta + $urandom_range(1, 12);
        pend_m = 0;
        for (int i = 0; i < N; i++) tbl[i] = 3'($urandom);
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            e_busy = (k <= total);
            e_done = (k == total + 1);
            e_x = '0; e_y = '0; e_wren = 1'b0; e_wd = '0;
            if (k <= P * N) begin
                ph = (k - 1) / N;
                pi = (k - 1) % N;
                e_x = 8'(pi % H);
                e_y = 7'(pi / H);
                e_wren = (ph != P - 1);
                e_wd = (!sk && ph == 0) ? 3'd0 : tbl[pi];
            end
            e_plot = (k > ds) && (k <= ds + N);
            e_vx = '0; e_vy = '0; e_vc = '0;
            if (e_plot) begin
                pi = k - ds - 1;
                e_vx = 8'(pi % H);
                e_vy = 7'(pi / H);
                e_vc = tbl[pi];
            end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL busy k=%0d got=%0b exp=%0b", k, busy, e_busy); end
            checks++; if (done !== e_done) begin failures++; $display("FAIL frame_done k=%0d got=%0b exp=%0b", k, done, e_done); end
            checks++; if (wren !== e_wren) begin failures++; $display("FAIL wren k=%0d got=%0b exp=%0b", k, wren, e_wren); end
            checks++; if (ox !== e_x) begin failures++; $display("FAIL addr_x k=%0d got=%0d exp=%0d", k, ox, e_x); end
            checks++; if (oy !== e_y) begin failures++; $display("FAIL addr_y k=%0d got=%0d exp=%0d", k, oy, e_y); end
            checks++; if (plot !== e_plot) begin failures++; $display("FAIL plot k=%0d got=%0b exp=%0b", k, plot, e_plot); end
            checks++; if (drop !== 8'(drop_m)) begin failures++; $display("FAIL drop_count k=%0d got=%0d exp=%0d", k, drop, drop_m); end
            if (e_wren) begin
                checks++; if (wrd !== e_wd) begin failures++; $display("FAIL wrdata k=%0d got=%0d exp=%0d", k, wrd, e_wd); end
            end
            if (e_plot) begin
                checks++; if (vx !== e_vx) begin failures++; $display("FAIL vga_x k=%0d got=%0d exp=%0d", k, vx, e_vx); end
                checks++; if (vy !== e_vy) begin failures++; $display("FAIL vga_y k=%0d got=%0d exp=%0d", k, vy, e_vy); end
                checks++; if (vc !== e_vc) begin failures++; $display("FAIL vga_colour k=%0d got=%0d exp=%0d", k, vc, e_vc); end
            end
            tick = 1'b0;
            if (k <= total) begin
                skip = 1'($urandom);
                case (mode)
                    M_TWO:   t = (k == ta) || (k == tb);
                    M_RAND:  t = ($urandom_range(0, 3) == 0);
                    M_ALL:   t = 1'b1;
                    default: t = 1'b0;
                endcase
                tick = t;
                if (t) begin
                    if (!pend_m) pend_m = 1;
                    else if (drop_m < 255) drop_m++;
                end
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int g = 0; g < n; g++) begin
            tick = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL idle_done got=%0b exp=0", done); end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; tick = 1'b1; skip = 1'b0; tick2 = 1'b0; skip2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (wren !== 1'b0) begin failures++; $display("FAIL rst_wren got=%0b exp=0", wren); end
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL rst_plot got=%0b exp=0", plot); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if ({ox, oy, vx, vy, wrd} !== '0) begin failures++; $display("FAIL rst_coords got=%0h exp=0", {ox, oy, vx, vy, wrd}); end
        checks++; if (drop !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop); end
        rstn = 1'b1;
        drop_m = 0; pend_m = 0;
        idle_check(2);
    endtask

    task automatic test_basic_frame;
        tick = 1'b1; skip = 1'b0;
        run_frame(1'b0, M_NONE);
        idle_check(2);
    endtask

    task automatic test_skip_clear;
        tick = 1'b1; skip = 1'b1;
        run_frame(1'b1, M_NONE);
        idle_check(2);
    endtask

    task automatic test_pending_drop;
        tick = 1'b1; skip = 1'b0;
        run_frame(1'b0, M_TWO);
        checks++; if (drop !== 8'd1) begin failures++; $display("FAIL two_ticks_drop got=%0d exp=1", drop); end
        skip = 1'b1; tick = 1'b0;
        run_frame(1'b1, M_NONE);
        idle_check(2);
    endtask

    task automatic test_tick_at_done;
        bit sk;
        tick = 1'b1; skip = 1'b0;
        run_frame(1'b0, M_NONE);
        sk = 1'($urandom);
        tick = 1'b1; skip = sk;
        run_frame(sk, M_NONE);
        idle_check(2);
    endtask

    task automatic test_saturate;
        bit sk;
        sk = 1'b0;
        tick = 1'b1; skip = sk;
        for (int f = 0; f < 9; f++) begin
            run_frame(sk, M_ALL);
            sk = 1'($urandom);
            skip = sk; tick = 1'b0;
        end
        run_frame(sk, M_NONE);
        checks++; if (drop !== 8'd255) begin failures++; $display("FAIL drop_saturate got=%0d exp=255", drop); end
        idle_check(2);
    endtask

    task automatic test_reset_mid;
        tick = 1'b1; skip = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            tick = 1'b0;
        end
        checks++; if ({ox, oy, wren} !== {8'd2, 7'd1, 1'b1}) begin failures++; $display("FAIL mid_compose_pos got=%0d,%0d,%0b exp=2,1,1", ox, oy, wren); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++; if (wren !== 1'b0) begin failures++; $display("FAIL abort_wren got=%0b exp=0", wren); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if ({ox, oy} !== '0) begin failures++; $display("FAIL abort_xy got=%0d,%0d exp=0,0", ox, oy); end
        drop_m = 0; pend_m = 0;
        idle_check(40);
        tick = 1'b1; skip = 1'b0;
        run_frame(1'b0, M_NONE);
        idle_check(1);
    endtask

    task automatic test_random;
        bit sk;
        for (int f = 0; f < 8; f++) begin
            sk = 1'($urandom);
            if (!pend_m) idle_check($urandom_range(0, 3));
            tick = !pend_m; skip = sk;
            run_frame(sk, M_RAND);
        end
        if (pend_m) begin
            tick = 1'b0; skip = 1'b0;
            run_frame(1'b0, M_NONE);
        end
        idle_check(2);
    endtask

    task automatic test_rdlat2;
        int np, pi;
        for (int i = 0; i < N; i++) tbl2[i] = 3'($urandom);
        np = 0;
        tick2 = 1'b1; skip2 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            tick2 = 1'b0;
            checks++; if (plot2 !== ((k >= 27) && (k <= 38))) begin failures++; $display("FAIL lat2_plot k=%0d got=%0b", k, plot2); end
            if (plot2) begin
                np++;
                pi = k - 27;
                checks++; if ({vx2, vy2} !== {8'(pi % H), 7'(pi / H)}) begin failures++; $display("FAIL lat2_coords k=%0d got=%0d,%0d exp=%0d,%0d", k, vx2, vy2, pi % H, pi / H); end
                checks++; if (vc2 !== tbl2[pi]) begin failures++; $display("FAIL lat2_colour k=%0d got=%0d exp=%0d", k, vc2, tbl2[pi]); end
            end
            if (k == 37 || k == 38) begin
                checks++; if ({busy2, wren2} !== 2'b10) begin failures++; $display("FAIL lat2_drain k=%0d busy/wren got=%0b%0b exp=10", k, busy2, wren2); end
            end
            checks++; if (done2 !== (k == 39)) begin failures++; $display("FAIL lat2_done k=%0d got=%0b", k, done2); end
        end
        checks++; if (np != N) begin failures++; $display("FAIL lat2_plot_count got=%0d exp=%0d", np, N); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ram1[i] = '0; ram2[i] = '0; tbl[i] = '0; tbl2[i] = '0;
        end
        test_reset;
        test_basic_frame;
        test_skip_clear;
        test_pending_drop;
        test_tick_at_done;
        test_saturate;
        test_reset_mid;
        test_random;
        test_rdlat2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
